// File: rtl/layer_engine_config_slave.sv
// Config-bus responder: decodes an address window, holds a bank of wide config
// registers for one PE sub-unit and acknowledges each request with a single pulse.
module layer_engine_config_slave #(
  parameter int unsigned C_DATA_WIDTH = 128,
  parameter int unsigned C_ADDR_BITS  = 4,
  parameter logic [15:0] C_BASE_ADDR  = 16'h0100
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [15:0]             i_config_address,
  input  logic                    i_config_wren,
  output logic                    o_config_wrack,
  input  logic                    i_config_rden,
  output logic                    o_config_rdack,
  input  logic [C_DATA_WIDTH-1:0] i_config_datain,
  output logic [C_DATA_WIDTH-1:0] o_config_dataout,
  input  logic                    i_unit_busy,
  output logic                    o_cfg_start,
  output logic [((1 << C_ADDR_BITS) - 2)*C_DATA_WIDTH-1:0] o_cfg_regs
);

  localparam int C_NUM_REGS = 1 << C_ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACK,
    S_RD_FETCH,
    S_RD_ACK,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [C_DATA_WIDTH-1:0] r_regs [2:C_NUM_REGS-1];
  logic [C_DATA_WIDTH-1:0] r_rd_data;
  logic [C_DATA_WIDTH-1:0] w_rd_value;
  logic                    r_err;
  logic                    r_start;
  logic                    r_wren_d;
  logic                    r_rden_d;

  logic                   w_hit;
  logic [C_ADDR_BITS-1:0] w_index;
  logic                   w_idle;
  logic                   w_active;
  logic                   w_accept_wr;
  logic                   w_accept_rd;
  logic                   w_err_set;
  logic                   w_err_clr;

  assign w_hit       = (i_config_address[15:C_ADDR_BITS] == C_BASE_ADDR[15:C_ADDR_BITS]);
  assign w_index     = i_config_address[C_ADDR_BITS-1:0];
  assign w_idle      = (r_state == S_IDLE);
  assign w_active    = (r_state == S_WR_ACK) || (r_state == S_RD_FETCH) || (r_state == S_RD_ACK);
  assign w_accept_wr = w_idle && w_hit && i_config_wren;
  assign w_accept_rd = w_idle && w_hit && i_config_rden && !i_config_wren;

  // A new request appearing mid-transaction is flagged, as is a simultaneous write+read.
  assign w_err_set = (w_idle && w_hit && i_config_wren && i_config_rden) ||
                     (w_active && w_hit && ((i_config_wren && !r_wren_d) ||
                                            (i_config_rden && !r_rden_d)));
  assign w_err_clr = w_accept_wr && (w_index == C_ADDR_BITS'(1)) && i_config_datain[0];

  always_comb begin
    w_rd_value = '0;
    if (w_index == C_ADDR_BITS'(1)) begin
      w_rd_value = {{(C_DATA_WIDTH-2){1'b0}}, i_unit_busy, r_err};
    end
    for (int i = 2; i < C_NUM_REGS; i++) begin
      if (w_index == C_ADDR_BITS'(i)) w_rd_value = r_regs[i];
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_wr)      w_next_state = S_WR_ACK;
        else if (w_accept_rd) w_next_state = S_RD_FETCH;
      end
      S_WR_ACK:   w_next_state = S_RELEASE;
      S_RD_FETCH: w_next_state = S_RD_ACK;
      S_RD_ACK:   w_next_state = S_RELEASE;
      S_RELEASE: begin
        if (!i_config_wren && !i_config_rden) w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rd_data <= '0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_wren_d  <= 1'b0;
      r_rden_d  <= 1'b0;
      for (int i = 2; i < C_NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state  <= w_next_state;
      r_wren_d <= i_config_wren;
      r_rden_d <= i_config_rden;
      r_start  <= w_accept_wr && (w_index == C_ADDR_BITS'(0)) && i_config_datain[0];
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
      if (w_accept_rd) r_rd_data <= w_rd_value;
      for (int i = 2; i < C_NUM_REGS; i++) begin
        if (w_accept_wr && (w_index == C_ADDR_BITS'(i))) r_regs[i] <= i_config_datain;
      end
    end
  end

  for (genvar g = 2; g < C_NUM_REGS; g++) begin : g_export
    assign o_cfg_regs[(g-2)*C_DATA_WIDTH +: C_DATA_WIDTH] = r_regs[g];
  end

  assign o_config_wrack   = (r_state == S_WR_ACK);
  assign o_config_rdack   = (r_state == S_RD_ACK);
  assign o_config_dataout = o_config_rdack ? r_rd_data : '0;
  assign o_cfg_start      = r_start;

endmodule
